snax_csr_launch_queue: RTL and testbench

SNAX_CSR_LAUNCH_QUEUE -- requirements
Module: snax_csr_launch_queue

---
 rtl/snax_csr_launch_pkg.sv | 26 ++
 rtl/snax_csr_launch_fifo.sv | 59 +++++
 rtl/snax_csr_launch_queue.sv | 167 ++++++++++++++++
 tb/tb_snax_csr_launch_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_csr_launch_pkg.sv
// Purpose: shared types and constants for the CSR launch queue (FSM states, status word layout).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snax_csr_launch_pkg;

    // Launch sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ARM   = 2'd2,
        ST_RUN   = 2'd3
    } launch_state_e;

    // Read-only status word indices
    localparam int unsigned RoIdxStatus     = 0;
    localparam int unsigned RoIdxBusyCycles = 1;
    localparam int unsigned RoIdxLaunches   = 2;
    localparam int unsigned RoIdxTimeouts   = 3;

    // Bit positions inside the status word
    localparam int unsigned StBitBusy    = 0;
    localparam int unsigned StBitTimeout = 1;
    localparam int unsigned StOccLsb     = 8;
    localparam int unsigned StOccWidth   = 8;

endpackage

// File: rtl/snax_csr_launch_fifo.sv
// Purpose: pending-launch queue; Depth entries of Width bits, head always visible on head_o.
// Latency: one cycle from push to visibility at head_o / occupancy_o.
// Backpressure: push ignored while full (even if popping the same cycle); pop ignored while empty.
// Ports: clk_i, rst_ni (async active-low), push_i/push_data_i, pop_i, head_o, full_o, empty_o, occupancy_o.
module snax_csr_launch_fifo #(
    parameter int unsigned Width = 192,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW:0]    occupancy_o
);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             push_en;
    logic             pop_en;

    assign full_o      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                         (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign head_o      = mem_q[rd_ptr_q[PtrW-1:0]];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: consumers only look at it while non-empty.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/snax_csr_launch_queue.sv
// Purpose: queues CSR launch configs and sequences them to an accelerator (issue, arm, run) with status counters.
// Latency: a config accepted in cycle t is offered on acc_cfg_o at t+1 at the earliest.
// Backpressure: csr_reg_set_ready_o = !full; acc_cfg_o held stable while acc_cfg_ready_i is low.
// Ports: csr_reg_set_* (launch handshake in), acc_cfg_* (config handshake out), acc_busy_i,
//        perf_clr_i (counter clear pulse), csr_reg_ro_set_o (status words).
module snax_csr_launch_queue
    import snax_csr_launch_pkg::*;
#(
    parameter int unsigned RegRWCount   = 6,
    parameter int unsigned RegROCount   = 4,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned Depth        = 4,
    parameter int unsigned ArmTimeout   = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
    input  logic                                     csr_reg_set_valid_i,
    output logic                                     csr_reg_set_ready_o,
    output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o,
    output logic [RegRWCount-1:0][RegDataWidth-1:0]  acc_cfg_o,
    output logic                                     acc_cfg_valid_o,
    input  logic                                     acc_cfg_ready_i,
    input  logic                                     acc_busy_i,
    input  logic                                     perf_clr_i
);

    localparam int unsigned CfgW = RegRWCount * RegDataWidth;
    localparam int unsigned OccW = $clog2(Depth) + 1;
    localparam int unsigned ArmW = (ArmTimeout > 1) ? $clog2(ArmTimeout) : 1;

    logic [CfgW-1:0]         fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OccW-1:0]         fifo_occ;
    logic                    push;
    logic                    pop;

    launch_state_e           state_q;
    logic                    acc_cfg_valid_q;
    logic [ArmW-1:0]         arm_cnt_q;
    logic                    arm_expired;
    logic                    launch_evt;
    logic                    timeout_evt;

    logic [RegDataWidth-1:0] busy_cnt_q, busy_cnt_d;
    logic [RegDataWidth-1:0] launch_cnt_q, launch_cnt_d;
    logic [RegDataWidth-1:0] timeout_cnt_q, timeout_cnt_d;
    logic                    sticky_to_q, sticky_to_d;

    assign push = csr_reg_set_valid_i && !fifo_full;
    assign pop  = (state_q == ST_ISSUE) && acc_cfg_ready_i;

    // Ready depends only on full, so a pop from a full queue re-opens it one cycle later.
    assign csr_reg_set_ready_o = !fifo_full;

    snax_csr_launch_fifo #(
        .Width (CfgW),
        .Depth (Depth)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (csr_reg_set_i),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (fifo_occ)
    );

    // Head only changes on pop, so it is stable for the whole ISSUE phase; zero outside it.
    assign acc_cfg_valid_o = acc_cfg_valid_q;
    assign acc_cfg_o       = acc_cfg_valid_q ? fifo_head : '0;

    assign arm_expired = (arm_cnt_q == ArmW'(ArmTimeout - 1));
    assign launch_evt  = (state_q == ST_RUN) && !acc_busy_i;
    assign timeout_evt = (state_q == ST_ARM) && !acc_busy_i && arm_expired;

    // Sequencer. A push into an empty queue already starts ISSUE so the config is
    // offered the cycle after acceptance, never in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            acc_cfg_valid_q <= 1'b0;
            arm_cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((!fifo_empty || push) && !acc_busy_i) begin
                        state_q         <= ST_ISSUE;
                        acc_cfg_valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (acc_cfg_ready_i) begin
                        state_q         <= ST_ARM;
                        acc_cfg_valid_q <= 1'b0;
                        arm_cnt_q       <= '0;
                    end
                end
                ST_ARM: begin
                    if (acc_busy_i) begin
                        state_q <= ST_RUN;
                    end else if (arm_expired) begin
                        state_q <= ST_IDLE;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!acc_busy_i) state_q <= ST_IDLE;
                end
                default: begin
                    state_q         <= ST_IDLE;
                    acc_cfg_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Performance counters; a clear pulse overrides any same-cycle increment.
    always_comb begin
        busy_cnt_d    = busy_cnt_q;
        launch_cnt_d  = launch_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        sticky_to_d   = sticky_to_q;
        if (acc_busy_i && (busy_cnt_q != '1)) busy_cnt_d = busy_cnt_q + 1'b1;
        if (launch_evt)  launch_cnt_d  = launch_cnt_q + 1'b1;
        if (timeout_evt) begin
            timeout_cnt_d = timeout_cnt_q + 1'b1;
            sticky_to_d   = 1'b1;
        end
        if (perf_clr_i) begin
            busy_cnt_d    = '0;
            launch_cnt_d  = '0;
            timeout_cnt_d = '0;
            sticky_to_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_cnt_q    <= '0;
            launch_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            sticky_to_q   <= 1'b0;
        end else begin
            busy_cnt_q    <= busy_cnt_d;
            launch_cnt_q  <= launch_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            sticky_to_q   <= sticky_to_d;
        end
    end

    always_comb begin
        csr_reg_ro_set_o = '0;
        csr_reg_ro_set_o[RoIdxStatus][StBitBusy] =
            (state_q != ST_IDLE) || !fifo_empty || acc_busy_i;
        csr_reg_ro_set_o[RoIdxStatus][StBitTimeout]          = sticky_to_q;
        csr_reg_ro_set_o[RoIdxStatus][StOccLsb +: StOccWidth] = StOccWidth'(fifo_occ);
        csr_reg_ro_set_o[RoIdxBusyCycles] = busy_cnt_q;
        csr_reg_ro_set_o[RoIdxLaunches]   = launch_cnt_q;
        csr_reg_ro_set_o[RoIdxTimeouts]   = timeout_cnt_q;
    end

endmodule

// File: tb/tb_snax_csr_launch_queue.sv
// Purpose: self-checking bench for snax_csr_launch_queue; queue/phase reference model plus handshake scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_snax_csr_launch_queue;

    localparam int RW    = 6;
    localparam int RO    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AT    = 16;

    typedef logic [RW-1:0][DW-1:0] cfg_t;
    typedef enum int {P_IDLE, P_ISSUE, P_ARM, P_RUN} phase_e;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    cfg_t in_cfg = '0;
    logic in_vld = 1'b0;
    logic in_rdy = 1'b0;
    logic in_busy = 1'b0;
    logic in_clr = 1'b0;

    logic                  set_ready;
    logic [RO-1:0][DW-1:0] ro;
    cfg_t                  acc_cfg;
    logic                  acc_vld;

    always #5 clk_i = ~clk_i;

    snax_csr_launch_queue #(
        .RegRWCount   (RW),
        .RegROCount   (RO),
        .RegDataWidth (DW),
        .Depth        (DEPTH),
        .ArmTimeout   (AT)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .csr_reg_set_i       (in_cfg),
        .csr_reg_set_valid_i (in_vld),
        .csr_reg_set_ready_o (set_ready),
        .csr_reg_ro_set_o    (ro),
        .acc_cfg_o           (acc_cfg),
        .acc_cfg_valid_o     (acc_vld),
        .acc_cfg_ready_i     (in_rdy),
        .acc_busy_i          (in_busy),
        .perf_clr_i          (in_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    // Reference model: pending configs, current launch phase, counters.
    cfg_t          mq[$];
    cfg_t          exp_q[$];
    phase_e        ph = P_IDLE;
    int            arm_idle = 0;
    logic [DW-1:0] m_busy = '0;
    logic [DW-1:0] m_launch = '0;
    logic [DW-1:0] m_to = '0;
    logic          m_sticky = 1'b0;

    task automatic chk(input string name, input logic [RW*DW-1:0] act, input logic [RW*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        for (int i = 0; i < RW; i++) c[i] = $urandom;
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        ph       = P_IDLE;
        arm_idle = 0;
        m_busy   = '0;
        m_launch = '0;
        m_to     = '0;
        m_sticky = 1'b0;
    endtask

    // One clock of the launch rules, using the inputs held during that cycle.
    task automatic model_step();
        bit     acc;
        bit     pop;
        phase_e nph;
        acc = in_vld && (mq.size() < DEPTH);
        pop = (ph == P_ISSUE) && in_rdy;
        nph = ph;
        case (ph)
            P_IDLE:  if ((mq.size() > 0 || acc) && !in_busy) nph = P_ISSUE;
            P_ISSUE: if (in_rdy) begin nph = P_ARM; arm_idle = 0; end
            P_ARM: begin
                if (in_busy) nph = P_RUN;
                else begin
                    arm_idle++;
                    if (arm_idle == AT) begin
                        nph = P_IDLE;
                        m_to++;
                        m_sticky = 1'b1;
                    end
                end
            end
            P_RUN: if (!in_busy) begin nph = P_IDLE; m_launch++; end
            default: nph = P_IDLE;
        endcase
        if (in_busy && m_busy != {DW{1'b1}}) m_busy++;
        if (in_clr) begin
            m_busy = '0; m_launch = '0; m_to = '0; m_sticky = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(in_cfg);
            exp_q.push_back(in_cfg);
        end
        ph = nph;
    endtask

    task automatic check_all();
        logic [DW-1:0] e0;
        cfg_t          ecfg;
        e0        = '0;
        e0[0]     = (ph != P_IDLE) || (mq.size() != 0) || in_busy;
        e0[1]     = m_sticky;
        e0[15:8]  = 8'(mq.size());
        ecfg      = (ph == P_ISSUE) ? mq[0] : '0;
        chk("ready", set_ready, mq.size() < DEPTH);
        chk("cfg_valid", acc_vld, ph == P_ISSUE);
        chk("cfg_data", acc_cfg, ecfg);
        chk("ro0_status", ro[0], e0);
        chk("ro1_busy_cycles", ro[1], m_busy);
        chk("ro2_launches", ro[2], m_launch);
        chk("ro3_timeouts", ro[3], m_to);
    endtask

    // Scoreboard monitor: every accelerator handshake must carry the oldest accepted config.
    always @(negedge clk_i) begin
        if (rst_ni && acc_vld && in_rdy) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: handshake with %0h, expected no handshake", acc_cfg);
            end else begin
                chk("sb_cfg", acc_cfg, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input cfg_t c, input logic r, input logic b, input logic clr);
        in_vld = v; in_cfg = c; in_rdy = r; in_busy = b; in_clr = clr;
        @(negedge clk_i);
        check_all();
        @(posedge clk_i);
        if (rst_ni) model_step();
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after a rising edge.
    task automatic do_reset();
        #3 rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        check_all();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    cfg_t c1, c2, c5;
    int   hs0;

    initial begin
        do_reset();
        chk("rst_ready", set_ready, 1'b1);

        // Single launch: mode word 3, busy for 10 cycles.
        c1 = rand_cfg(); c1[0] = 32'd3;
        cyc(1, c1, 1, 0, 0);
        chk("s1_valid_next_cycle", acc_vld, 1'b1);
        cyc(0, rand_cfg(), 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, rand_cfg(), 1, 1, 0);
        cyc(0, rand_cfg(), 1, 0, 0);
        chk("s1_ro2", ro[2], 32'd1);
        chk("s1_ro1", ro[1], 32'd10);
        chk("s1_busy_bit", ro[0][0], 1'b0);

        // Arm timeout, then the next queued config is issued.
        cyc(0, rand_cfg(), 0, 0, 1);
        c1 = rand_cfg(); c2 = rand_cfg();
        cyc(1, c1, 1, 0, 0);
        cyc(1, c2, 1, 0, 0);
        for (int i = 0; i < AT; i++) cyc(0, rand_cfg(), 0, 0, 0);
        chk("s3_ro3", ro[3], 32'd1);
        chk("s3_sticky", ro[0][1], 1'b1);
        chk("s3_valid_idle", acc_vld, 1'b0);
        cyc(0, rand_cfg(), 0, 0, 0);
        chk("s3_next_valid", acc_vld, 1'b1);
        chk("s3_next_cfg", acc_cfg, c2);

        // Ready held low for 7 cycles in ISSUE.
        hs0 = hs_cnt;
        for (int i = 0; i < 7; i++) begin
            cyc(0, rand_cfg(), 0, 0, 0);
            chk("s6_cfg_stable", acc_cfg, c2);
        end
        cyc(0, rand_cfg(), 1, 0, 0);
        chk("s6_valid_dropped", acc_vld, 1'b0);
        cyc(0, rand_cfg(), 0, 0, 0);
        cyc(0, rand_cfg(), 0, 0, 0);
        chk("s6_one_pop", hs_cnt, hs0 + 1);
        for (int i = 0; i < AT + 1; i++) cyc(0, rand_cfg(), 0, 0, 0);

        // Clear in the same cycle as RUN->IDLE.
        cyc(1, rand_cfg(), 1, 0, 0);
        cyc(0, rand_cfg(), 1, 0, 0);
        cyc(0, rand_cfg(), 0, 1, 0);
        cyc(0, rand_cfg(), 0, 1, 0);
        cyc(0, rand_cfg(), 0, 0, 1);
        chk("s4_ro2_cleared", ro[2], 32'd0);
        chk("s4_ro3_cleared", ro[3], 32'd0);
        chk("s4_sticky_cleared", ro[0][1], 1'b0);

        // Reset during RUN with two configs queued.
        cyc(1, rand_cfg(), 1, 0, 0);
        cyc(1, rand_cfg(), 1, 0, 0);
        cyc(1, rand_cfg(), 0, 1, 0);
        cyc(0, rand_cfg(), 0, 1, 0);
        chk("s5_pre_occ", ro[0][15:8], 8'd2);
        do_reset();
        chk("s5_occ", ro[0][15:8], 8'd0);
        chk("s5_valid", acc_vld, 1'b0);
        chk("s5_cfg", acc_cfg, '0);
        chk("s5_ro1", ro[1], 32'd0);
        chk("s5_ro2", ro[2], 32'd0);
        chk("s5_ro3", ro[3], 32'd0);

        // Five back-to-back launches into a stalled accelerator.
        for (int i = 0; i < 5; i++) cyc(1, rand_cfg(), 0, 0, 0);
        chk("s2_ready_low", set_ready, 1'b0);
        chk("s2_occ4", ro[0][15:8], 8'd4);
        c5 = rand_cfg();
        cyc(1, c5, 1, 0, 0);
        chk("s2_ready_back", set_ready, 1'b1);
        cyc(1, c5, 0, 0, 0);
        chk("s2_occ_refill", ro[0][15:8], 8'd4);

        // Randomized traffic with a sticky busy line.
        for (int i = 0; i < 400; i++) begin
            logic b;
            b = in_busy;
            if ($urandom_range(0, 3) == 0) b = ~b;
            cyc(1'($urandom_range(0, 1)), rand_cfg(), 1'($urandom_range(0, 3) != 0), b,
                1'($urandom_range(0, 31) == 0));
        end
        cyc(0, rand_cfg(), 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
